// File: rtl/tsc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tsc_control_unit
// Purpose  : Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit
//            TSC CPU. Optional memory-wait timeout: define CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tsc_control_unit #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           opcode,
    input  logic [5:0]           func_code,
    input  logic                 input_ready,
    output logic                 read_m,
    output logic                 write_m,
    output logic                 i_or_d,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_src,
    output logic                 ir_write,
    output logic                 i_mem_write,
    output logic                 d_mem_write,
    output logic [3:0]           alu_op,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 alu_src_swap,
    output logic                 reg_write,
    output logic [1:0]           reg_write_src,
    output logic [1:0]           reg_dst,
    output logic                 output_write,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 is_halted,
    output logic                 fault
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;
    localparam logic [2:0] c_ST_FAULT  = 3'd6;

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_ORR = 4'd3;
    localparam logic [3:0] c_ALU_EQ  = 4'd8;
    localparam logic [3:0] c_ALU_NE  = 4'd9;
    localparam logic [3:0] c_ALU_GTZ = 4'd10;
    localparam logic [3:0] c_ALU_LTZ = 4'd11;

    localparam logic [1:0] c_SRCB_ONE  = 2'd0;
    localparam logic [1:0] c_SRCB_REG  = 2'd1;
    localparam logic [1:0] c_SRCB_IMM  = 2'd2;
    localparam logic [1:0] c_SRCB_ZERO = 2'd3;

    localparam logic [1:0] c_PC_JUMP   = 2'd1;
    localparam logic [1:0] c_PC_BRANCH = 2'd2;
    localparam logic [1:0] c_PC_REG    = 2'd3;

    localparam logic [1:0] c_WSRC_IMM = 2'd0;
    localparam logic [1:0] c_WSRC_ALU = 2'd1;
    localparam logic [1:0] c_WSRC_MDR = 2'd2;
    localparam logic [1:0] c_WSRC_PC  = 2'd3;

    localparam logic [1:0] c_DST_RT = 2'd0;
    localparam logic [1:0] c_DST_RD = 2'd1;
    localparam logic [1:0] c_DST_R2 = 2'd2;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] w_state_sel;
    logic       w_retire;

    // Instruction classes, decoded from the IR fields held by the datapath.
    logic w_is_branch, w_is_adi, w_is_ori, w_is_lhi, w_is_lwd, w_is_swd;
    logic w_is_jmp, w_is_jal, w_is_r, w_is_ralu, w_is_jpr, w_is_jrl;
    logic w_is_wwd, w_is_hlt;

    assign w_is_branch = (opcode[3:2] == 2'b00);
    assign w_is_adi    = (opcode == 4'd4);
    assign w_is_ori    = (opcode == 4'd5);
    assign w_is_lhi    = (opcode == 4'd6);
    assign w_is_lwd    = (opcode == 4'd7);
    assign w_is_swd    = (opcode == 4'd8);
    assign w_is_jmp    = (opcode == 4'd9);
    assign w_is_jal    = (opcode == 4'd10);
    assign w_is_r      = (opcode == 4'd15);
    assign w_is_ralu   = w_is_r && (func_code < 6'd8);
    assign w_is_jpr    = w_is_r && (func_code == 6'd25);
    assign w_is_jrl    = w_is_r && (func_code == 6'd26);
    assign w_is_wwd    = w_is_r && (func_code == 6'd28);
    assign w_is_hlt    = w_is_r && (func_code == 6'd29);

    assign i_mem_write  = 1'b0;
    assign alu_src_swap = 1'b0;
    assign is_halted    = (r_state == c_ST_HALT);

    always_comb begin
        w_state_nxt   = r_state;
        w_retire      = 1'b0;
        read_m        = 1'b0;
        write_m       = 1'b0;
        i_or_d        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        ir_write      = 1'b0;
        d_mem_write   = 1'b0;
        alu_op        = c_ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = c_SRCB_ONE;
        reg_write     = 1'b0;
        reg_write_src = c_WSRC_IMM;
        reg_dst       = c_DST_RT;
        output_write  = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                read_m = 1'b1;
                if (input_ready) begin
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                alu_src_b   = c_SRCB_IMM;
                w_state_nxt = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_FETCH;
                w_retire    = 1'b1;
                if (w_is_branch) begin
                    alu_src_a     = 1'b1;
                    pc_write_cond = 1'b1;
                    pc_src        = c_PC_BRANCH;
                    case (opcode[1:0])
                        2'd0:    begin alu_op = c_ALU_NE;  alu_src_b = c_SRCB_REG;  end
                        2'd1:    begin alu_op = c_ALU_EQ;  alu_src_b = c_SRCB_REG;  end
                        2'd2:    begin alu_op = c_ALU_GTZ; alu_src_b = c_SRCB_ZERO; end
                        default: begin alu_op = c_ALU_LTZ; alu_src_b = c_SRCB_ZERO; end
                    endcase
                end else if (w_is_jmp || w_is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = c_PC_JUMP;
                    if (w_is_jal) begin
                        reg_write     = 1'b1;
                        reg_dst       = c_DST_R2;
                        reg_write_src = c_WSRC_PC;
                    end
                end else if (w_is_jpr || w_is_jrl) begin
                    pc_write = 1'b1;
                    pc_src   = c_PC_REG;
                    if (w_is_jrl) begin
                        reg_write     = 1'b1;
                        reg_dst       = c_DST_R2;
                        reg_write_src = c_WSRC_PC;
                    end
                end else if (w_is_lhi) begin
                    reg_write     = 1'b1;
                    reg_dst       = c_DST_RT;
                    reg_write_src = c_WSRC_IMM;
                end else if (w_is_wwd) begin
                    output_write = 1'b1;
                end else if (w_is_hlt) begin
                    w_state_nxt = c_ST_HALT;
                end else if (w_is_adi || w_is_ori || w_is_lwd || w_is_swd) begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = c_SRCB_IMM;
                    alu_op      = w_is_ori ? c_ALU_ORR : c_ALU_ADD;
                    w_retire    = 1'b0;
                    w_state_nxt = (w_is_lwd || w_is_swd) ? c_ST_MEM : c_ST_WB;
                end else if (w_is_ralu) begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = c_SRCB_REG;
                    alu_op      = {1'b0, func_code[2:0]};
                    w_retire    = 1'b0;
                    w_state_nxt = c_ST_WB;
                end
            end
            c_ST_MEM: begin
                // Same ALU setup as EXEC keeps the data address stable.
                i_or_d    = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_op    = c_ALU_ADD;
                if (w_is_lwd) begin
                    read_m = 1'b1;
                end else begin
                    write_m     = 1'b1;
                    d_mem_write = 1'b1;
                end
                if (input_ready) begin
                    if (w_is_lwd) begin
                        w_state_nxt = c_ST_WB;
                    end else begin
                        w_state_nxt = c_ST_FETCH;
                        w_retire    = 1'b1;
                    end
                end
            end
            c_ST_WB: begin
                reg_write     = 1'b1;
                reg_dst       = w_is_ralu ? c_DST_RD : c_DST_RT;
                reg_write_src = w_is_lwd ? c_WSRC_MDR : c_WSRC_ALU;
                w_retire      = 1'b1;
                w_state_nxt   = c_ST_FETCH;
            end
            c_ST_HALT:  w_state_nxt = c_ST_HALT;
            c_ST_FAULT: w_state_nxt = c_ST_FAULT;
            default:    w_state_nxt = c_ST_FETCH;
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               w_waiting;
    logic               w_timeout;

    assign w_waiting   = ((r_state == c_ST_FETCH) || (r_state == c_ST_MEM)) && !input_ready;
    assign w_timeout   = w_waiting && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_state_sel = w_timeout ? c_ST_FAULT : w_state_nxt;
    assign fault       = (r_state == c_ST_FAULT);

    // Any non-waiting cycle clears the count, so it starts at 0 on FETCH/MEM entry.
    always_ff @(posedge clk) begin
        if (reset || !w_waiting) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_state_sel      = w_state_nxt;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_FETCH;
            num_inst <= '0;
        end else begin
            r_state <= w_state_sel;
            if (w_retire) begin
                num_inst <= num_inst + WORD_SIZE'(1);
            end
        end
    end

endmodule
`default_nettype wire
